// File: rtl/sram_arb_rr.sv
// Round-robin arbiter granting NCH req/ack requesters access to one single-ported SRAM controller.
// Optional access timeout enabled by defining SRAM_ARB_TIMEOUT_EN (abort flagged on err).
module sram_arb_rr #(
    parameter int NCH    = 4,
    parameter int AW     = 22,
    parameter int DW     = 32,
    parameter int BW     = 4,
    parameter int TO_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      req,
    input  logic [NCH-1:0]      we,
    input  logic [NCH*AW-1:0]   addr,
    input  logic [NCH*DW-1:0]   wdata,
    input  logic [NCH*BW-1:0]   bin,
    output logic [NCH-1:0]      ack,
    output logic [NCH-1:0]      err,
    output logic [NCH*DW-1:0]   rdata,
    output logic                busy,
    output logic [AW-1:0]       sram_addr,
    output logic [DW-1:0]       sram_data_write,
    output logic                sram_cs,
    output logic                sram_we,
    output logic [BW-1:0]       sram_bin,
    input  logic [DW-1:0]       sram_data_out,
    input  logic                sram_ready
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE_WAIT,
        DONE_WAIT,
        RESP
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] pick;
    logic [PW-1:0] next_ptr;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LIM = 8'(TO_CYC);
    logic [7:0]     timer;
    logic [NCH-1:0] err_q;
    assign err = err_q;
`else
    assign err = '0;
`endif

    assign busy     = (state != IDLE);
    assign next_ptr = (gnt == PW'(NCH - 1)) ? '0 : gnt + 1'b1;

    // First requesting channel at or after ptr, searched cyclically.
    always_comb begin
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && req[(int'(ptr) + k) % NCH]) begin
                found = 1'b1;
                pick  = PW'((int'(ptr) + k) % NCH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            ptr             <= '0;
            gnt             <= '0;
            ack             <= '0;
            rdata           <= '0;
            sram_addr       <= '0;
            sram_data_write <= '0;
            sram_cs         <= 1'b0;
            sram_we         <= 1'b0;
            sram_bin        <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
            timer           <= '0;
            err_q           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if ((|req) && sram_ready) begin
                        gnt             <= pick;
                        sram_cs         <= 1'b1;
                        sram_addr       <= addr[int'(pick)*AW +: AW];
                        sram_data_write <= wdata[int'(pick)*DW +: DW];
                        sram_we         <= we[pick];
                        sram_bin        <= bin[int'(pick)*BW +: BW];
`ifdef SRAM_ARB_TIMEOUT_EN
                        timer           <= '0;
`endif
                        state           <= ISSUE_WAIT;
                    end
                end
                ISSUE_WAIT, DONE_WAIT: begin
`ifdef SRAM_ARB_TIMEOUT_EN
                    timer <= timer + 8'd1;
                    if (timer == TO_LIM) begin
                        sram_cs    <= 1'b0;
                        ack[gnt]   <= 1'b1;
                        err_q[gnt] <= 1'b1;
                        ptr        <= next_ptr;
                        state      <= RESP;
                    end else
`endif
                    if (state == ISSUE_WAIT) begin
                        if (!sram_ready) begin
                            sram_cs <= 1'b0;
                            state   <= DONE_WAIT;
                        end
                    end else if (sram_ready) begin
                        // sram_we still holds the direction latched at grant time
                        if (!sram_we) begin
                            rdata[int'(gnt)*DW +: DW] <= sram_data_out;
                        end
                        ack[gnt] <= 1'b1;
                        ptr      <= next_ptr;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    ack   <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
                    err_q <= '0;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
